// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of the 64-bit data memory.
// Zero-cycle grant, registered per-port read data with rvalid pulse.
module dm_port_arbiter #(
  parameter int DW        = 64,
  parameter int AW        = 64,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] dm_address,
  output logic [DW-1:0] dm_write_data,
  output logic          dm_mem_write,
  output logic          dm_mem_read,
  input  logic [DW-1:0] dm_read_data
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    S_NONE = 2'd0,
    S_P0   = 2'd1,
    S_P1   = 2'd2
  } port_e;

  port_e          last_q, last_d;
  port_e          sel;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           prio_q, prio_d;
  logic [DW-1:0]  rdata0_q, rdata0_d;
  logic [DW-1:0]  rdata1_q, rdata1_d;
  logic           rvalid0_q, rvalid0_d;
  logic           rvalid1_q, rvalid1_d;
  logic           burst_hit;

  assign burst_hit = (cnt_q >= CMAX);

  always_comb begin
    sel = S_NONE;
    unique case (1'b1)
      (req0 && req1): begin
        unique case (last_q)
          S_P0:    sel = burst_hit ? S_P1 : S_P0;
          S_P1:    sel = burst_hit ? S_P0 : S_P1;
          default: sel = prio_q ? S_P1 : S_P0;
        endcase
      end
      (req0 && !req1): sel = S_P0;
      (!req0 && req1): sel = S_P1;
      default:         sel = S_NONE;
    endcase
  end

  assign gnt0 = (sel == S_P0) && rst_n;
  assign gnt1 = (sel == S_P1) && rst_n;

  always_comb begin
    dm_address    = '0;
    dm_write_data = '0;
    dm_mem_write  = 1'b0;
    dm_mem_read   = 1'b0;
    unique case (1'b1)
      gnt0: begin
        dm_address    = addr0;
        dm_write_data = wdata0;
        dm_mem_write  = we0;
        dm_mem_read   = ~we0;
      end
      gnt1: begin
        dm_address    = addr1;
        dm_write_data = wdata1;
        dm_mem_write  = we1;
        dm_mem_read   = ~we1;
      end
      default: ;
    endcase
  end

  always_comb begin
    last_d = sel;
    if (sel == S_NONE) begin
      cnt_d = '0;
    end else if (sel == last_q) begin
      cnt_d = burst_hit ? CMAX : cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(1);
    end
    unique case (sel)
      S_P0:    prio_d = 1'b1;
      S_P1:    prio_d = 1'b0;
      default: prio_d = prio_q;
    endcase
  end

  always_comb begin
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = rvalid0_d ? dm_read_data : rdata0_q;
    rdata1_d  = rvalid1_d ? dm_read_data : rdata1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= S_NONE;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule
